// File: rtl/sum_fifo_if.sv
// rtl/sum_fifo_if.sv - handshake bundle between adder, sum FIFO and its consumer
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface sum_fifo_if #(
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic          in_valid;
   logic [3:0]    sum;
   logic          carry;
   logic          in_ready;
   logic          out_valid;
   logic [4:0]    out_data;
   logic          out_ready;
   logic [LW-1:0] level;
   logic [7:0]    carry_cnt;

   modport master (
      output in_valid, sum, carry, out_ready,
      input  in_ready, out_valid, out_data, level, carry_cnt
   );

   modport slave (
      input  in_valid, sum, carry, out_ready,
      output in_ready, out_valid, out_data, level, carry_cnt
   );
endinterface

// File: rtl/sum_fifo.sv
// rtl/sum_fifo.sv - first-word fall-through FIFO of {carry,sum} adder results
// Also keeps a saturating count of accepted results that carried out.
module sum_fifo #(
   parameter int DEPTH = 4
) (
   input logic        clk,
   input logic        rst,
   sum_fifo_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

   logic [4:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic [7:0]    carry_cnt_q, carry_cnt_d;
   logic          push, pop;

   // Handshake qualifiers come from registered level only, so in_ready never sees out_ready.
   assign push = bus.in_valid && (level_q != FULL_LEVEL);
   assign pop  = bus.out_ready && (level_q != '0);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      carry_cnt_d = carry_cnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (bus.carry && (carry_cnt_q != 8'hFF)) begin
            carry_cnt_d = carry_cnt_q + 8'd1;
         end
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   level_d = level_q + (AW + 1)'(1);
         2'b01:   level_d = level_q - (AW + 1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         carry_cnt_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         carry_cnt_q <= carry_cnt_d;
      end
   end

   // Storage is never reset; empty slots are masked off at the output.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= {bus.carry, bus.sum};
      end
   end

   assign bus.in_ready  = (level_q != FULL_LEVEL);
   assign bus.out_valid = (level_q != '0);
   assign bus.out_data  = (level_q != '0) ? mem_q[rd_ptr_q] : 5'b00000;
   assign bus.level     = level_q;
   assign bus.carry_cnt = carry_cnt_q;
endmodule

// File: doc/sum_fifo.md
SUM_FIFO -- requirements
Module: sum_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of result entries; SHALL be a power of two, >= 2.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock domain.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: in_valid  input  1  upstream asserts when sum/carry hold a new 4-bit adder result.
REQ-005 Port: sum  input  4  adder sum word.
REQ-006 Port: carry  input  1  adder carry-out.
REQ-007 Port: in_ready  output  1  FIFO can accept a result this cycle.
REQ-008 Port: out_valid  output  1  out_data holds the oldest stored result.
REQ-009 Port: out_data  output  5  oldest result, packed {carry, sum[3:0]}.
REQ-010 Port: out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 Port: level  output  log2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-012 Port: carry_cnt  output  8  count of accepted results with carry=1, saturating.

Function
REQ-013 Push SHALL occur on a rising clk when in_valid=1 and in_ready=1; {carry,sum} is written at wr_ptr, and wr_ptr advances by 1.
REQ-014 Pop SHALL occur on a rising clk when out_valid=1 and out_ready=1; rd_ptr advances by 1.
REQ-015 wr_ptr and rd_ptr SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 without any gap.
REQ-016 in_ready SHALL equal (level != DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL equal (level != 0); there is no combinational path from in_valid to out_valid.
REQ-018 Latency: a result pushed at edge N SHALL appear on out_data with out_valid=1 after edge N when the FIFO was empty (first-word fall-through, 1 cycle).
REQ-019 out_data SHALL equal the entry at rd_ptr when out_valid=1, and 5'b00000 when out_valid=0.
REQ-020 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 Results SHALL leave the FIFO in arrival order, with no loss and no duplication.
REQ-022 Level update: push only -> +1; pop only -> -1; push and pop together -> unchanged.
REQ-023 When full (level=DEPTH), in_valid SHALL be ignored; a pop in that cycle frees a slot that is usable from the next cycle onward.
REQ-024 When empty, out_ready SHALL be ignored, and level SHALL NOT underflow.
REQ-025 Push and pop in the same cycle at level=1 SHALL leave level=1, with out_data showing the newly pushed entry.
REQ-026 carry_cnt SHALL increment by 1 on each push with carry=1.
REQ-027 carry_cnt SHALL hold at 8'hFF once reached; pops SHALL NOT affect carry_cnt.

Reset
REQ-028 While rst=1 at a clk edge, the following SHALL be cleared: wr_ptr=0, rd_ptr=0, level=0, carry_cnt=0.
REQ-029 While rst=1 at a clk edge, no push or pop SHALL take effect, regardless of in_valid or out_ready.
REQ-030 After the reset edge, outputs SHALL be: out_valid=0, out_data=0, in_ready=1, level=0, carry_cnt=0.
REQ-031 Storage array contents need no reset; they SHALL be unobservable while their slots are empty.
REQ-032 Reset asserted mid-operation SHALL discard all stored entries in the same edge; the following cycle behaves as after power-up reset.

Verification
REQ-033 Reset, then push {1,4'hA} with out_ready=0 -> next cycle: out_valid=1, out_data=5'h1A, level=1, carry_cnt=1.
REQ-034 DEPTH=4: push 5'h03, 5'h0F, 5'h11, 5'h1E back-to-back with out_ready=0 -> level=4, in_ready=0; a 5th push of 5'h07 is ignored; drain yields 03,0F,11,1E in order, then out_valid=0, out_data=0.
REQ-035 Fill to level=4, then hold in_valid=1 and out_ready=1 for 12 cycles with incrementing data -> level stays at 3 or 4, pointers wrap at least twice, output sequence matches input order exactly.
REQ-036 At level=1, push and pop in the same cycle -> level stays 1, out_data equals the new entry; at level=0, out_ready=1 only -> level stays 0, pointers unchanged.
REQ-037 Push 300 results with carry=1 while draining -> carry_cnt=8'hFF with no wrap; then assert rst with level=3 -> next cycle: level=0, out_valid=0, carry_cnt=0, in_ready=1.
